// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the register scoreboard.
//   REG_ZERO  : integer register number that is hardwired to zero
//   NREG      : registers per file
//   FMODE_*   : register-file select (integer / float)
package cpu_pkg;
   localparam logic [4:0] REG_ZERO  = 5'd0;
   localparam int         NREG      = 32;
   localparam logic       FMODE_INT = 1'b0;
   localparam logic       FMODE_FLT = 1'b1;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode / writeback bus between the decode stage and the scoreboard.
//   master : decode + writeback side (drives dec_*, wb_*, reads issue/stall)
//   slave  : scoreboard (reads dec_*, wb_*, drives issue/stall)
interface reg_scoreboard_if;
   import cpu_pkg::*;
   logic       dec_valid;
   logic [4:0] dec_rs_no;
   logic       dec_rs_fmode;
   logic       dec_rs_use;
   logic [4:0] dec_rt_no;
   logic       dec_rt_fmode;
   logic       dec_rt_use;
   logic [4:0] dec_rd_no;
   logic       dec_rd_fmode;
   logic       dec_rd_we;
   logic       wb_valid;
   logic [4:0] wb_rd_no;
   logic       wb_fmode;
   logic       issue;
   logic       stall;

   modport master (
      output dec_valid, dec_rs_no, dec_rs_fmode, dec_rs_use,
             dec_rt_no, dec_rt_fmode, dec_rt_use,
             dec_rd_no, dec_rd_fmode, dec_rd_we,
             wb_valid, wb_rd_no, wb_fmode,
      input  issue, stall
   );

   modport slave (
      input  dec_valid, dec_rs_no, dec_rs_fmode, dec_rs_use,
             dec_rt_no, dec_rt_fmode, dec_rt_use,
             dec_rd_no, dec_rd_fmode, dec_rd_we,
             wb_valid, wb_rd_no, wb_fmode,
      output issue, stall
   );
endinterface

// File: rtl/scoreboard_bank.sv
// One register file's pending-write vector.
//   clk, rst          : clock, synchronous active-high reset
//   set_i / set_no_i  : mark a register pending (wins over a same-bit clear)
//   clr_i / clr_no_i  : retire a pending register
//   rs/rt/rd_no_i     : lookup addresses; *_busy_o are the current bits
//   busy_o            : whole pending vector
// With HARDWIRED_ZERO the register-0 bit is held at 0 so it never hazards.
module scoreboard_bank
   import cpu_pkg::*;
#(
   parameter bit HARDWIRED_ZERO = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_i,
   input  logic [4:0]      set_no_i,
   input  logic            clr_i,
   input  logic [4:0]      clr_no_i,
   input  logic [4:0]      rs_no_i,
   input  logic [4:0]      rt_no_i,
   input  logic [4:0]      rd_no_i,
   output logic            rs_busy_o,
   output logic            rt_busy_o,
   output logic            rd_busy_o,
   output logic [NREG-1:0] busy_o
);
   logic [NREG-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_i) busy_d[clr_no_i] = 1'b0;
      // set applied after clear: a new writer beats the old writer's writeback
      if (set_i) busy_d[set_no_i] = 1'b1;
      if (HARDWIRED_ZERO) busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign rs_busy_o = busy_q[rs_no_i];
   assign rt_busy_o = busy_q[rt_no_i];
   assign rd_busy_o = busy_q[rd_no_i];
   assign busy_o    = busy_q;
endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage issue controller for the integer and float register files.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : decode request, writeback, issue/stall decision
//   busy_int/flt  : pending-write bits per file
//   outstanding   : writes in flight (integer r0 writes are not tracked)
//   stall_cycles  : saturating count of stalled cycles
// issue/stall are combinational on the current decode; state moves at the edge.
module reg_scoreboard
   import cpu_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int WB_BYPASS       = 1
) (
   input  logic              clk,
   input  logic              rst,
   reg_scoreboard_if.slave   bus,
   output logic [NREG-1:0]   busy_int,
   output logic [NREG-1:0]   busy_flt,
   output logic [3:0]        outstanding,
   output logic [31:0]       stall_cycles
);
   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   logic [3:0]  outstanding_q, outstanding_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   logic int_rs, int_rt, int_rd, flt_rs, flt_rt, flt_rd;
   logic rs_busy, rt_busy, rd_busy;
   logic rs_byp, rt_byp;
   logic rs_hz, rt_hz, waw_hz, full_hz, hazard;
   logic counted_write, wb_hit, wb_zero;
   logic issue_w, stall_w, inc, dec;

   // Integer r0 is a write-sink: it issues but is never tracked.
   assign counted_write = bus.dec_rd_we &
                          ~(bus.dec_rd_fmode == FMODE_INT && bus.dec_rd_no == REG_ZERO);
   assign wb_zero = (bus.wb_fmode == FMODE_INT) && (bus.wb_rd_no == REG_ZERO);

   assign inc = issue_w & counted_write;
   // Only a writeback that actually retires a pending bit releases a slot.
   assign wb_hit = bus.wb_fmode ? busy_flt[bus.wb_rd_no] : busy_int[bus.wb_rd_no];
   assign dec    = bus.wb_valid & wb_hit;

   scoreboard_bank #(.HARDWIRED_ZERO(1'b1)) u_int (
      .clk      (clk),
      .rst      (rst),
      .set_i    (inc & (bus.dec_rd_fmode == FMODE_INT)),
      .set_no_i (bus.dec_rd_no),
      .clr_i    (bus.wb_valid & (bus.wb_fmode == FMODE_INT)),
      .clr_no_i (bus.wb_rd_no),
      .rs_no_i  (bus.dec_rs_no),
      .rt_no_i  (bus.dec_rt_no),
      .rd_no_i  (bus.dec_rd_no),
      .rs_busy_o(int_rs),
      .rt_busy_o(int_rt),
      .rd_busy_o(int_rd),
      .busy_o   (busy_int)
   );

   scoreboard_bank #(.HARDWIRED_ZERO(1'b0)) u_flt (
      .clk      (clk),
      .rst      (rst),
      .set_i    (inc & (bus.dec_rd_fmode == FMODE_FLT)),
      .set_no_i (bus.dec_rd_no),
      .clr_i    (bus.wb_valid & (bus.wb_fmode == FMODE_FLT)),
      .clr_no_i (bus.wb_rd_no),
      .rs_no_i  (bus.dec_rs_no),
      .rt_no_i  (bus.dec_rt_no),
      .rd_no_i  (bus.dec_rd_no),
      .rs_busy_o(flt_rs),
      .rt_busy_o(flt_rt),
      .rd_busy_o(flt_rd),
      .busy_o   (busy_flt)
   );

   assign rs_busy = bus.dec_rs_fmode ? flt_rs : int_rs;
   assign rt_busy = bus.dec_rt_fmode ? flt_rt : int_rt;
   assign rd_busy = bus.dec_rd_fmode ? flt_rd : int_rd;

   // A same-cycle writeback forwards its value to a reader, so the read
   // need not wait for the bit to clear.
   assign rs_byp = (WB_BYPASS != 0) && bus.wb_valid &&
                   (bus.wb_fmode == bus.dec_rs_fmode) && (bus.wb_rd_no == bus.dec_rs_no);
   assign rt_byp = (WB_BYPASS != 0) && bus.wb_valid &&
                   (bus.wb_fmode == bus.dec_rt_fmode) && (bus.wb_rd_no == bus.dec_rt_no);

   assign rs_hz   = bus.dec_rs_use & rs_busy & ~rs_byp;
   assign rt_hz   = bus.dec_rt_use & rt_busy & ~rt_byp;
   // No bypass for WAW: the bit must be seen clear before the new writer claims it.
   assign waw_hz  = bus.dec_rd_we & rd_busy;
   assign full_hz = counted_write & (outstanding_q == MAX_OUT);
   assign hazard  = rs_hz | rt_hz | waw_hz | full_hz;

   assign issue_w   = bus.dec_valid & ~hazard & ~rst;
   assign stall_w   = bus.dec_valid &  hazard & ~rst;
   assign bus.issue = issue_w;
   assign bus.stall = stall_w;

   always_comb begin
      outstanding_d = outstanding_q;
      unique case ({inc, dec})
         2'b10:   if (outstanding_q != MAX_OUT) outstanding_d = outstanding_q + 4'd1;
         2'b01:   if (outstanding_q != 4'd0)    outstanding_d = outstanding_q - 4'd1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall_w && stall_cycles_q != 32'hFFFF_FFFF)
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q  <= '0;
         stall_cycles_q <= '0;
      end else begin
         outstanding_q  <= outstanding_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign outstanding  = outstanding_q;
   assign stall_cycles = stall_cycles_q;

   // A writeback must retire something that is pending.
   a_wb_busy: assert property (@(posedge clk) disable iff (rst)
      (bus.wb_valid && !wb_zero) |-> wb_hit);
endmodule
